prog_run_ctrl: RTL and testbench

- Synthesizable program-load / run / register-dump controller for the riscv core.
- Streams a program into instruction memory over a valid/ready port while the core is held in reset.
- Releases the core for a programmable number of cycles, then freezes it.
- Streams every register-file entry out over a valid/ready dump port.
- Generalises the load/run/dump flow to configurable width, memory depth, register count and run length, with backpressure and overflow detection.

---
 rtl/prog_run_ctrl.sv | 169 ++++++++++++++++
 tb/tb_prog_run_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prog_run_ctrl
// Brief    : Loads a program into instruction memory, runs the core for a set
//            number of cycles, then streams the whole register file out.
// Revision : 1.0 - initial release
// ============================================================================
module prog_run_ctrl #(
    parameter  int XLEN       = 32,
    parameter  int IMEM_DEPTH = 256,
    parameter  int NREGS      = 32,
    parameter  int CNT_W      = 16,
    localparam int AW         = $clog2(IMEM_DEPTH),
    localparam int RW         = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             ld_valid,
    input  logic [XLEN-1:0]  ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             imem_we,
    output logic [AW-1:0]    imem_waddr,
    output logic [XLEN-1:0]  imem_wdata,
    output logic             core_rst,
    output logic             core_en,
    output logic [RW-1:0]    rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic             dump_valid,
    output logic [RW-1:0]    dump_idx,
    output logic [XLEN-1:0]  dump_data,
    input  logic             dump_ready,
    output logic             busy,
    output logic             done,
    output logic             err_overflow,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DUMP = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [AW-1:0] c_last_addr = AW'(IMEM_DEPTH - 1);
    localparam logic [RW-1:0] c_last_reg  = RW'(NREGS - 1);

    // Output flag vector: {core_rst, core_en, ld_ready, busy, done, dump_valid}
    function automatic logic [5:0] flags_for(input state_t s);
        logic [5:0] f;
        case (s)
            S_IDLE:  f = 6'b100000;
            S_LOAD:  f = 6'b101100;
            S_RUN:   f = 6'b010100;
            S_DUMP:  f = 6'b000101;
            S_FIN:   f = 6'b100010;
            default: f = 6'b100000;
        endcase
        return f;
    endfunction

    state_t           r_state;
    logic [5:0]       r_flags;
    logic [CNT_W-1:0] r_run_cycles;
    logic [CNT_W-1:0] r_cycle_count;
    logic [AW-1:0]    r_waddr;
    logic [RW-1:0]    r_dump_idx;
    logic             r_err_overflow;

    logic             w_beat;
    logic [CNT_W-1:0] w_count_inc;

    assign w_beat      = ld_valid & r_flags[3];
    assign w_count_inc = r_cycle_count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_flags        <= flags_for(S_IDLE);
            r_run_cycles   <= '0;
            r_cycle_count  <= '0;
            r_waddr        <= '0;
            r_dump_idx     <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_run_cycles   <= run_cycles;
                        r_cycle_count  <= '0;
                        r_waddr        <= '0;
                        r_dump_idx     <= '0;
                        r_err_overflow <= 1'b0;
                        r_state        <= S_LOAD;
                        r_flags        <= flags_for(S_LOAD);
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        r_waddr <= r_waddr + 1'b1;
                        if (ld_last) begin
                            // A zero-length run skips straight to the dump.
                            if (r_run_cycles == '0) begin
                                r_state <= S_DUMP;
                                r_flags <= flags_for(S_DUMP);
                            end else begin
                                r_state <= S_RUN;
                                r_flags <= flags_for(S_RUN);
                            end
                        end else if (r_waddr == c_last_addr) begin
                            r_err_overflow <= 1'b1;
                            r_state        <= S_FIN;
                            r_flags        <= flags_for(S_FIN);
                        end
                    end
                end
                S_RUN: begin
                    r_cycle_count <= w_count_inc;
                    if (w_count_inc == r_run_cycles) begin
                        r_state <= S_DUMP;
                        r_flags <= flags_for(S_DUMP);
                    end
                end
                S_DUMP: begin
                    if (dump_ready) begin
                        if (r_dump_idx == c_last_reg) begin
                            r_state <= S_FIN;
                            r_flags <= flags_for(S_FIN);
                        end else begin
                            r_dump_idx <= r_dump_idx + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_flags <= flags_for(S_IDLE);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_flags <= flags_for(S_IDLE);
                end
            endcase
        end
    end

    assign core_rst     = r_flags[5];
    assign core_en      = r_flags[4];
    assign ld_ready     = r_flags[3];
    assign busy         = r_flags[2];
    assign done         = r_flags[1];
    assign dump_valid   = r_flags[0];

    assign imem_we      = w_beat;
    assign imem_waddr   = r_waddr;
    assign imem_wdata   = ld_data;

    assign rf_raddr     = r_dump_idx;
    assign dump_idx     = r_dump_idx;
    assign dump_data    = rf_rdata;

    assign err_overflow = r_err_overflow;
    assign cycle_count  = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_prog_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_run_ctrl
// Brief    : Self-checking bench: toy core + program/register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_run_ctrl;

    localparam int XL    = 32;
    localparam int DEPTH = 8;
    localparam int NR    = 32;
    localparam int CW    = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = $clog2(NR);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] run_cycles = '0;
    logic          ld_valid = 1'b0;
    logic [XL-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [XL-1:0] imem_wdata;
    logic          core_rst;
    logic          core_en;
    logic [RW-1:0] rf_raddr;
    logic [XL-1:0] rf_rdata;
    logic          dump_valid;
    logic [RW-1:0] dump_idx;
    logic [XL-1:0] dump_data;
    logic          dump_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          err_overflow;
    logic [CW-1:0] cycle_count;

    prog_run_ctrl #(.XLEN(XL), .IMEM_DEPTH(DEPTH), .NREGS(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .run_cycles(run_cycles),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .core_en(core_en), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_ready(dump_ready), .busy(busy), .done(done),
        .err_overflow(err_overflow), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [XL-1:0] reg_init(input int i);
        return XL'(i) * 32'h0001_0003;
    endfunction

    // Toy core: each enabled cycle adds imem[pc] into register (pc mod 31)+1.
    logic [XL-1:0] mem [DEPTH] = '{default: '0};
    logic [XL-1:0] regs [NR];
    int            pc = 0;
    always @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
        if (core_rst) begin
            pc <= 0;
            for (int i = 0; i < NR; i++) regs[i] <= reg_init(i);
        end else if (core_en) begin
            regs[pc % (NR - 1) + 1] <= regs[pc % (NR - 1) + 1] + mem[pc % DEPTH];
            pc <= pc + 1;
        end
    end
    assign rf_rdata = regs[rf_raddr];

    // Reference: memory image from accepted beats, registers from program arithmetic.
    logic [XL-1:0] mmem [DEPTH] = '{default: '0};
    logic [XL-1:0] exp_regs [NR];

    function automatic void build_exp(input int rc);
        for (int i = 0; i < NR; i++) exp_regs[i] = reg_init(i);
        for (int c = 0; c < rc; c++)
            exp_regs[c % (NR - 1) + 1] = exp_regs[c % (NR - 1) + 1] + mmem[c % DEPTH];
    endfunction

    int rmode = 0;
    int ph    = 0;
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0: dump_ready = 1'b1;
            1: begin dump_ready = (ph == 2); ph = (ph + 1) % 3; end
            default: dump_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int            n_we, n_en, n_done, n_beats, exp_waddr, exp_idx;
    int            first_dump_cyc, last_beat_cyc;
    bit            dump_seen, prev_stall;
    logic [RW-1:0] prev_idx;
    logic [XL-1:0] prev_data;

    task automatic clear_counters();
        n_we = 0; n_en = 0; n_done = 0; n_beats = 0;
        exp_waddr = 0; exp_idx = 0; dump_seen = 0; prev_stall = 0;
    endtask

    initial forever begin
        @(negedge clk);
        if (imem_we) begin
            chk("imem_waddr", 64'(imem_waddr), 64'(exp_waddr % DEPTH));
            chk("imem_wdata", 64'(imem_wdata), 64'(ld_data));
            exp_waddr++;
            n_we++;
        end
        if (core_en) n_en++;
        if (done) n_done++;
        if (dump_valid) begin
            if (!dump_seen) begin dump_seen = 1; first_dump_cyc = cyc; end
            if (prev_stall) begin
                chk("stall_idx_stable", 64'(dump_idx), 64'(prev_idx));
                chk("stall_data_stable", 64'(dump_data), 64'(prev_data));
            end
            if (dump_ready) begin
                chk("dump_idx", 64'(dump_idx), 64'(exp_idx % NR));
                chk("dump_data", 64'(dump_data), 64'(exp_regs[exp_idx % NR]));
                exp_idx++;
                n_beats++;
            end
            prev_stall = !dump_ready;
            prev_idx   = dump_idx;
            prev_data  = dump_data;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic feed(input int n, input bit last, input bit spam, output int acc);
        bit stopped;
        int gaps;
        stopped = 0;
        acc = 0;
        for (int i = 0; i < n && !stopped; i++) begin
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin ld_valid = 0; @(posedge clk); #1; end
            ld_valid = 1;
            ld_data  = $urandom;
            ld_last  = last && (i == n - 1);
            start    = spam && (i == 1);
            @(negedge clk);
            if (ld_ready) begin
                mmem[acc % DEPTH] = ld_data;
                acc++;
                last_beat_cyc = cyc;
                @(posedge clk); #1;
            end else begin
                stopped = 1;
            end
        end
        start   = 0;
        ld_last = 0;
    endtask

    typedef struct {
        int nwords;
        bit last;
        int rc;
        int rmode;
        bit spam;
        int exp_writes;
        bit exp_of;
    } sess_t;

    task automatic run_session(input sess_t s);
        int acc;
        int g;
        bit spammed;
        clear_counters();
        rmode   = s.rmode;
        spammed = 0;
        start = 1; run_cycles = CW'(s.rc);
        @(posedge clk); #1;
        start = 0; run_cycles = CW'($urandom);
        feed(s.nwords, s.last, s.spam, acc);
        if (!s.exp_of) build_exp(s.rc);
        g = 0;
        while (n_done == 0 && g < 3000) begin
            @(negedge clk);
            g++;
            if (s.spam && dump_valid && !spammed) begin
                spammed = 1;
                @(posedge clk); #1; start = 1;
                @(posedge clk); #1; start = 0;
            end
        end
        chk("done_seen", 64'(n_done != 0), 64'd1);
        repeat (4) @(posedge clk);
        #1 ld_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("done_pulses", 64'(n_done), 64'd1);
        chk("accepted_beats", 64'(acc), 64'(s.exp_writes));
        chk("imem_writes", 64'(n_we), 64'(s.exp_writes));
        chk("err_overflow", 64'(err_overflow), 64'(s.exp_of));
        chk("core_en_cycles", 64'(n_en), s.exp_of ? 64'd0 : 64'(s.rc));
        chk("cycle_count", 64'(cycle_count), s.exp_of ? 64'd0 : 64'(s.rc));
        chk("dump_beats", 64'(n_beats), s.exp_of ? 64'd0 : 64'(NR));
        chk("busy_after", 64'(busy), 64'd0);
        chk("core_rst_after", 64'(core_rst), 64'd1);
        if (!s.exp_of)
            chk("dump_latency", 64'(first_dump_cyc - last_beat_cyc), 64'(s.rc + 1));
    endtask

    sess_t tbl [7];

    initial begin
        int acc;
        int g;
        sess_t r;

        //          nwords last rc  rmode spam writes of
        tbl[0] = '{4,     1,   10,  0,    0,   4,     0};
        tbl[1] = '{4,     1,   10,  1,    0,   4,     0};
        tbl[2] = '{10,    0,   5,   0,    0,   8,     1};
        tbl[3] = '{4,     1,   0,   0,    0,   4,     0};
        tbl[4] = '{8,     1,   3,   2,    1,   8,     0};
        tbl[5] = '{1,     1,   1,   2,    1,   1,     0};
        tbl[6] = '{3,     1,   37,  1,    0,   3,     0};

        // Reset state, with ld_valid driven to show it is ignored.
        rst = 1; ld_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_core_rst", 64'(core_rst), 64'd1);
        chk("rst_core_en", 64'(core_en), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_imem_waddr", 64'(imem_waddr), 64'd0);
        chk("rst_dump_valid", 64'(dump_valid), 64'd0);
        chk("rst_dump_idx", 64'(dump_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err_overflow", 64'(err_overflow), 64'd0);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
        ld_valid = 0;
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_session(tbl[i]);

        // Reset asserted five cycles into RUN.
        clear_counters();
        rmode = 0;
        start = 1; run_cycles = CW'(20);
        @(posedge clk); #1 start = 0;
        feed(4, 1, 0, acc);
        chk("abort_accepted", 64'(acc), 64'd4);
        g = 0;
        while (n_en < 5 && g < 200) begin @(posedge clk); g++; end
        #1 rst = 1;
        @(negedge clk);
        chk("abort_core_en_cycles", 64'(n_en), 64'd5);
        chk("abort_core_rst", 64'(core_rst), 64'd1);
        chk("abort_core_en", 64'(core_en), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ld_ready", 64'(ld_ready), 64'd0);
        chk("abort_dump_valid", 64'(dump_valid), 64'd0);
        chk("abort_cycle_count", 64'(cycle_count), 64'd0);
        @(posedge clk); #1 rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_stays_idle", 64'(busy), 64'd0);
        run_session(tbl[0]);

        // Randomized sessions; every third one overflows the memory.
        for (int k = 0; k < 9; k++) begin
            if (k % 3 == 2) begin
                r.nwords = $urandom_range(DEPTH, DEPTH + 3);
                r.last = 0; r.exp_writes = DEPTH; r.exp_of = 1;
            end else begin
                r.nwords = $urandom_range(1, DEPTH);
                r.last = 1; r.exp_writes = r.nwords; r.exp_of = 0;
            end
            r.rc    = $urandom_range(0, 30);
            r.rmode = $urandom_range(0, 2);
            r.spam  = 1'($urandom_range(0, 1));
            run_session(r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
